// File: rtl/seq_det_pkg.sv
// Shared types and constants for the "1101" serial detector sequencer.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    REPORT
  } ctrl_state_t;

  typedef enum logic [2:0] {
    S0,
    S1,
    S2,
    S3,
    S4
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage : seq_det_pkg

// File: rtl/seq_det_ctrl_if.sv
// Word-in / result-out handshake bundle between a producer/consumer and the sequencer.
interface seq_det_ctrl_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              keep_hist;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  logic              res_hit;

  modport master (
    output in_valid, in_data, keep_hist, res_ready,
    input  in_ready, res_valid, res_count, res_hit
  );

  modport slave (
    input  in_valid, in_data, keep_hist, res_ready,
    output in_ready, res_valid, res_count, res_hit
  );
endinterface : seq_det_ctrl_if

// File: rtl/seq_moore_det.sv
// Moore "1101" detector with overlap; out is high while the state is S4.
module seq_moore_det
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic in,
  output logic out
);

  det_state_t r_state;
  det_state_t w_next;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_state <= S0;
    else if (clr) r_state <= S0;
    else if (en)  r_state <= w_next;
  end

  // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S0:      w_next = (in == PATTERN[3]) ? S1 : S0;
      S1:      w_next = (in == PATTERN[2]) ? S2 : S0;
      S2:      w_next = (in == PATTERN[1]) ? S3 : S2;
      S3:      w_next = (in == PATTERN[0]) ? S4 : S0;
      S4:      w_next = in ? S2 : S0;  // overlap: trailing "1" restarts as "11"
      default: w_next = S0;
    endcase
  end

  assign out = (r_state == S4);

endmodule : seq_moore_det

// File: rtl/seq_det_ctrl.sv
// Word sequencer: serialises words MSB-first into the detector, counts matches per
// word and in a saturating running total, and reports each word over valid/ready.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int TOT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_ctrl_if.slave    bus,
  output logic [TOT_W-1:0] total,
  output logic             busy
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next;
  logic [WORD_W-1:0] r_sreg;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              r_shifted;
  logic [CNT_W-1:0]  r_count;
  logic [TOT_W-1:0]  r_total;

  logic w_accept;
  logic w_det_clr;
  logic w_det_en;
  logic w_det_out;
  logic w_count_hit;

  assign w_accept    = bus.in_valid && (r_state == IDLE);
  assign w_det_clr   = w_accept && !bus.keep_hist;
  assign w_det_en    = (r_state == SHIFT);
  // The detector output reflects a bit one cycle after it was shifted in.
  assign w_count_hit = r_shifted && w_det_out;

  seq_moore_det u_det (
    .clk (clk),
    .rst (rst),
    .clr (w_det_clr),
    .en  (w_det_en),
    .in  (r_sreg[WORD_W-1]),
    .out (w_det_out)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)                w_next = SHIFT;
      SHIFT:   if (r_bit_cnt == LAST_BIT)   w_next = DRAIN;
      DRAIN:                                w_next = REPORT;
      REPORT:  if (bus.res_ready)           w_next = IDLE;
      default:                              w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sreg    <= '0;
      r_bit_cnt <= '0;
      r_shifted <= 1'b0;
      r_count   <= '0;
      r_total   <= '0;
    end else begin
      r_state   <= w_next;
      r_shifted <= (r_state == SHIFT);
      if (w_accept) begin
        r_sreg    <= bus.in_data;
        r_bit_cnt <= '0;
        r_count   <= '0;
      end else if (r_state == SHIFT) begin
        r_sreg    <= {r_sreg[WORD_W-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_count_hit) begin
        r_count <= r_count + 1'b1;
        if (r_total != '1) r_total <= r_total + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.res_valid = (r_state == REPORT);
  assign bus.res_count = r_count;
  assign bus.res_hit   = (r_count != '0);
  assign total         = r_total;
  assign busy          = (r_state != IDLE);

endmodule : seq_det_ctrl
